// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the memory req/ack handshake,
// and feeds a one-entry output register backed by a one-word skid buffer.
module fetch_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  br_taken_i,
  input  logic [ADDR_WIDTH-1:0] br_target_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ack_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  inst_valid_o,
  output logic [31:0]           inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN} state_t;

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_next;
  logic [ADDR_WIDTH-1:0] r_tgt, w_tgt_next;
  logic [31:0]           r_skid, w_skid_next;
  logic [ADDR_WIDTH-1:0] r_skid_pc, w_skid_pc_next;
  logic                  r_valid, w_valid_next;
  logic [31:0]           r_inst, w_inst_next;
  logic [ADDR_WIDTH-1:0] r_inst_pc, w_inst_pc_next;

  logic                  w_ack;
  logic                  w_slot_free;
  logic                  w_consumed;
  logic [ADDR_WIDTH-1:0] w_tgt_in;
  logic [ADDR_WIDTH-1:0] w_pc_inc;

  // During DRAIN the PC is left untouched, so it still names the abandoned
  // request and the address stays stable until that transfer is acked.
  assign mem_req_o    = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign mem_addr_o   = r_pc;
  assign inst_valid_o = r_valid;
  assign inst_o       = r_inst;
  assign inst_pc_o    = r_inst_pc;

  assign w_ack       = mem_req_o && mem_ack_i;
  assign w_slot_free = !r_valid || !stall_i;
  assign w_consumed  = r_valid && !stall_i;
  assign w_tgt_in    = br_target_i & ~ADDR_WIDTH'(3);
  assign w_pc_inc    = r_pc + ADDR_WIDTH'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_tgt     <= '0;
      r_skid    <= '0;
      r_skid_pc <= '0;
      r_valid   <= 1'b0;
      r_inst    <= '0;
      r_inst_pc <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_tgt     <= w_tgt_next;
      r_skid    <= w_skid_next;
      r_skid_pc <= w_skid_pc_next;
      r_valid   <= w_valid_next;
      r_inst    <= w_inst_next;
      r_inst_pc <= w_inst_pc_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_tgt_next     = r_tgt;
    w_skid_next    = r_skid;
    w_skid_pc_next = r_skid_pc;
    w_valid_next   = r_valid;
    w_inst_next    = r_inst;
    w_inst_pc_next = r_inst_pc;

    unique case (r_state)
      S_IDLE: begin
        w_state_next = S_FETCH;
        if (br_taken_i) begin
          w_pc_next    = w_tgt_in;
          w_valid_next = 1'b0;
        end
      end
      S_FETCH: begin
        if (br_taken_i) begin
          w_valid_next = 1'b0;
          if (w_ack) begin
            w_pc_next = w_tgt_in;
          end else begin
            w_tgt_next   = w_tgt_in;
            w_state_next = S_DRAIN;
          end
        end else if (w_ack) begin
          w_pc_next = w_pc_inc;
          if (w_slot_free) begin
            w_inst_next    = mem_rdata_i;
            w_inst_pc_next = r_pc;
            w_valid_next   = 1'b1;
          end else begin
            w_skid_next    = mem_rdata_i;
            w_skid_pc_next = r_pc;
            w_state_next   = S_HOLD;
          end
        end else if (w_consumed) begin
          w_valid_next = 1'b0;
        end
      end
      S_HOLD: begin
        if (br_taken_i) begin
          w_valid_next = 1'b0;
          w_pc_next    = w_tgt_in;
          w_state_next = S_FETCH;
        end else if (!stall_i) begin
          w_inst_next    = r_skid;
          w_inst_pc_next = r_skid_pc;
          w_valid_next   = 1'b1;
          w_state_next   = S_FETCH;
        end
      end
      S_DRAIN: begin
        // Latest redirect wins; the acked word is always thrown away here.
        if (br_taken_i) begin
          w_tgt_next   = w_tgt_in;
          w_valid_next = 1'b0;
        end else if (w_ack) begin
          w_pc_next    = r_tgt;
          w_state_next = S_FETCH;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a memory model returns addr^KEY, and every
// instruction consumed downstream is checked against a queue of expected PCs.
module tb_fetch_ctrl;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  fetch_ctrl #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .inst_valid_o(inst_valid_o),
    .inst_o      (inst_o),
    .inst_pc_o   (inst_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, score any consumed instruction, then advance.
  task automatic step(input logic st, input logic br, input logic [31:0] tgt, input logic ack_en);
    logic [31:0] e;
    stall_i     = st;
    br_taken_i  = br;
    br_target_i = tgt;
    mem_ack_i   = ack_en && mem_req_o;
    mem_rdata_i = mem_addr_o ^ KEY;
    if (!rst && inst_valid_o && !stall_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $error("FAIL extra_inst: observed pc %h expected none", inst_pc_o);
      end else begin
        e = exp_q.pop_front();
        chk("inst_pc", inst_pc_o, e);
        chk("inst", inst_o, e ^ KEY);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall_i = 0; br_taken_i = 0; br_target_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_valid", {31'b0, inst_valid_o}, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_pc", inst_pc_o, 32'h0);
    chk("rst_req", {31'b0, mem_req_o}, 32'h0);

    // Sequential fetch from reset, then a 3-cycle stall with the skid buffer.
    exp_q.push_back(32'h0);  exp_q.push_back(32'h4);  exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);  exp_q.push_back(32'h10); exp_q.push_back(32'h14);
    rst = 1'b0;
    step(0, 0, 0, 1);                                   // C0: IDLE dead cycle
    chk("c1_req", {31'b0, mem_req_o}, 32'h1);
    chk("c1_addr", mem_addr_o, 32'h0);
    chk("c1_valid", {31'b0, inst_valid_o}, 32'h0);
    step(0, 0, 0, 1);                                   // C1
    chk("c2_valid", {31'b0, inst_valid_o}, 32'h1);
    step(0, 0, 0, 1);                                   // C2
    step(0, 0, 0, 1);                                   // C3
    step(1, 0, 0, 1);                                   // C4: stall, 0xC to skid
    chk("hold_req", {31'b0, mem_req_o}, 32'h0);
    chk("hold_pc", inst_pc_o, 32'h8);
    step(1, 0, 0, 1);                                   // C5
    step(1, 0, 0, 1);                                   // C6
    step(0, 0, 0, 1);                                   // C7
    step(0, 0, 0, 1);                                   // C8
    step(0, 0, 0, 1);                                   // C9

    // Redirect with ack in the same cycle; low target bits must be dropped.
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    step(0, 1, 32'h103, 1);                             // C10
    chk("br_addr", mem_addr_o, 32'h100);
    chk("br_flush", {31'b0, inst_valid_o}, 32'h0);
    step(0, 0, 0, 1);                                   // C11
    step(0, 0, 0, 1);                                   // C12
    step(0, 0, 0, 1);                                   // C13

    // Redirects during a slow transfer: drain, discard, latest target wins.
    exp_q.push_back(32'h300); exp_q.push_back(32'h304);
    step(0, 1, 32'h200, 0);                             // C14
    chk("drain_req", {31'b0, mem_req_o}, 32'h1);
    chk("drain_addr0", mem_addr_o, 32'h10C);
    step(0, 1, 32'h300, 0);                             // C15
    chk("drain_addr1", mem_addr_o, 32'h10C);
    step(0, 0, 0, 0);                                   // C16
    step(0, 0, 0, 0);                                   // C17
    chk("drain_valid", {31'b0, inst_valid_o}, 32'h0);
    step(0, 0, 0, 1);                                   // C18: late ack, discarded
    chk("drain_next", mem_addr_o, 32'h300);
    chk("drain_discard", {31'b0, inst_valid_o}, 32'h0);
    step(0, 0, 0, 1);                                   // C19
    step(0, 0, 0, 1);                                   // C20

    // PC wrap at the top of the address space.
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    step(0, 1, 32'hFFFF_FFFE, 1);                       // C21
    chk("wrap_top", mem_addr_o, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);                                   // C22
    chk("wrap_zero", mem_addr_o, 32'h0);
    step(0, 0, 0, 1);                                   // C23
    step(0, 0, 0, 1);                                   // C24

    // Reset while draining, with an ack in the reset cycle.
    exp_q.push_back(32'h0);
    step(0, 1, 32'h400, 0);                             // C25
    chk("pre_rst_req", {31'b0, mem_req_o}, 32'h1);
    rst = 1'b1;
    step(0, 0, 0, 1);                                   // C26
    chk("rst2_valid", {31'b0, inst_valid_o}, 32'h0);
    chk("rst2_inst", inst_o, 32'h0);
    chk("rst2_pc", inst_pc_o, 32'h0);
    chk("rst2_req", {31'b0, mem_req_o}, 32'h0);
    rst = 1'b0;
    step(0, 0, 0, 1);                                   // C27
    chk("restart_req", {31'b0, mem_req_o}, 32'h1);
    chk("restart_addr", mem_addr_o, 32'h0);
    step(0, 0, 0, 1);                                   // C28
    step(0, 0, 0, 0);                                   // C29
    chk("q_empty", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
